parking_lane_scheduler: RTL and testbench

//  Shares the parking slot map between NUM_LANES gate lanes (entry or exit). Arbitrates lane

---
 rtl/parking_lane_scheduler.sv | 169 ++++++++++++++++
 tb/tb_parking_lane_scheduler.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/parking_lane_scheduler.sv
// rtl/parking_lane_scheduler.sv - round-robin gate-lane arbiter owning the parking slot map and door sequencing
// Optional build macro PARK_EXIT_PRIORITY_EN: pending exit requests win arbitration over entries.
module parking_lane_scheduler #(
    parameter int NUM_LANES   = 4,
    parameter int SLOTS       = 4,
    parameter int DOOR_CYCLES = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_LANES-1:0]   req_valid,
    input  logic [NUM_LANES-1:0]   req_exit,
    input  logic [2*NUM_LANES-1:0] req_slot,
    output logic [NUM_LANES-1:0]   resp_valid,
    output logic                   resp_ok,
    output logic [1:0]             resp_slot,
    output logic                   door_open,
    output logic                   full_light,
    output logic [SLOTS-1:0]       occupancy,
    output logic [2:0]             free_count
);
    localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int CW = $clog2(DOOR_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, EXEC, DOOR} state_e;

    state_e           state_q, state_d;
    logic [LW-1:0]    rr_q, rr_d, lane_q, lane_d;
    logic             exit_q, exit_d;
    logic [1:0]       slot_q, slot_d;
    logic [SLOTS-1:0] occ_q, occ_d;
    logic [2:0]       free_q, free_d;
    logic             full_q, full_d;
    logic [CW-1:0]    door_cnt_q, door_cnt_d;

    logic [NUM_LANES-1:0] cand;
    logic                 grant_any;
    logic [LW-1:0]        grant_lane;
    logic [LW-1:0]        scan_idx;
    logic                 exec_ok;
    logic [1:0]           exec_slot;
    logic [SLOTS-1:0]     exec_occ;

    function automatic logic [2:0] free_of(input logic [SLOTS-1:0] occ);
        logic [2:0] n;
        n = 3'(SLOTS);
        for (int s = 0; s < SLOTS; s++) begin
            if (occ[s]) n = n - 3'd1;
        end
        return n;
    endfunction

    // Round-robin scan starting at the pointer; exits form a higher-priority group when enabled.
    always_comb begin
`ifdef PARK_EXIT_PRIORITY_EN
        cand = ((req_valid & req_exit) != '0) ? (req_valid & req_exit) : req_valid;
`else
        cand = req_valid;
`endif
        grant_any  = 1'b0;
        grant_lane = '0;
        scan_idx   = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            scan_idx = LW'((int'(rr_q) + k) % NUM_LANES);
            if (!grant_any && cand[scan_idx]) begin
                grant_any  = 1'b1;
                grant_lane = scan_idx;
            end
        end
    end

    // Outcome of the latched request against the current slot map.
    always_comb begin
        exec_ok   = 1'b0;
        exec_slot = 2'd0;
        exec_occ  = occ_q;
        for (int s = 0; s < SLOTS; s++) begin
            if (exit_q) begin
                if (slot_q == 2'(s) && occ_q[s]) begin
                    exec_ok     = 1'b1;
                    exec_slot   = 2'(s);
                    exec_occ[s] = 1'b0;
                end
            end else if (!exec_ok && !occ_q[s]) begin
                exec_ok     = 1'b1;
                exec_slot   = 2'(s);
                exec_occ[s] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            rr_q       <= '0;
            lane_q     <= '0;
            exit_q     <= 1'b0;
            slot_q     <= 2'd0;
            occ_q      <= '0;
            free_q     <= 3'(SLOTS);
            full_q     <= 1'b0;
            door_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            lane_q     <= lane_d;
            exit_q     <= exit_d;
            slot_q     <= slot_d;
            occ_q      <= occ_d;
            free_q     <= free_d;
            full_q     <= full_d;
            door_cnt_q <= door_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        lane_d     = lane_q;
        exit_d     = exit_q;
        slot_d     = slot_q;
        occ_d      = occ_q;
        door_cnt_d = door_cnt_q;
        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    state_d = EXEC;
                    lane_d  = grant_lane;
                    for (int l = 0; l < NUM_LANES; l++) begin
                        if (grant_lane == LW'(l)) begin
                            exit_d = req_exit[l];
                            slot_d = req_slot[2*l +: 2];
                        end
                    end
                end
            end
            EXEC: begin
                rr_d  = (lane_q == LW'(NUM_LANES - 1)) ? '0 : lane_q + LW'(1);
                occ_d = exec_occ;
                if (exec_ok) begin
                    state_d    = DOOR;
                    door_cnt_d = CW'(DOOR_CYCLES - 1);
                end else begin
                    state_d = IDLE;
                end
            end
            DOOR: begin
                if (door_cnt_q == '0) state_d = IDLE;
                else                  door_cnt_d = door_cnt_q - CW'(1);
            end
            default: state_d = IDLE;
        endcase
        free_d = free_of(occ_d);
        full_d = &occ_d;
    end

    always_comb begin
        resp_valid = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            resp_valid[l] = (state_q == EXEC) && (lane_q == LW'(l));
        end
        resp_ok   = (state_q == EXEC) && exec_ok;
        resp_slot = ((state_q == EXEC) && exec_ok) ? exec_slot : 2'd0;
        door_open = (state_q == DOOR);
    end

    assign occupancy  = occ_q;
    assign free_count = free_q;
    assign full_light = full_q;
endmodule

// File: tb/tb_parking_lane_scheduler.sv
// tb/tb_parking_lane_scheduler.sv - directed and randomized checks against a transaction-level parking lot model
module tb_parking_lane_scheduler;
    localparam int N = 4;
    localparam int S = 4;
    localparam int D = 3;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_exit = '0;
    logic [2*N-1:0] req_slot = '0;
    logic [N-1:0]   resp_valid;
    logic           resp_ok;
    logic [1:0]     resp_slot;
    logic           door_open;
    logic           full_light;
    logic [S-1:0]   occupancy;
    logic [2:0]     free_count;

    parking_lane_scheduler #(.NUM_LANES(N), .SLOTS(S), .DOOR_CYCLES(D)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_exit(req_exit), .req_slot(req_slot),
        .resp_valid(resp_valid), .resp_ok(resp_ok), .resp_slot(resp_slot),
        .door_open(door_open), .full_light(full_light),
        .occupancy(occupancy), .free_count(free_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Lot model: one transaction decided at grant time, its effects scheduled on absolute cycles.
    int cyc;
    bit pend[N];
    bit pexit[N];
    int pslot[N];
    bit m_occ[S];
    bit m_new[S];
    int m_rr;
    int next_arb;
    int resp_cyc;
    int resp_lane;
    int resp_slot_e;
    bit resp_ok_e;

    function automatic logic [S-1:0] occ_vec();
        logic [S-1:0] v;
        for (int s = 0; s < S; s++) v[s] = m_occ[s];
        return v;
    endfunction

    task automatic drive();
        for (int l = 0; l < N; l++) begin
            req_valid[l]       = pend[l];
            req_exit[l]        = pexit[l];
            req_slot[2*l +: 2] = 2'(pslot[l]);
        end
    endtask

    task automatic req(input int lane, input bit ex, input int slot);
        pend[lane]  = 1'b1;
        pexit[lane] = ex;
        pslot[lane] = slot;
    endtask

    task automatic arbitrate();
        int win;
        int l;
        win = -1;
`ifdef PARK_EXIT_PRIORITY_EN
        for (int k = 0; k < N; k++) begin
            l = (m_rr + k) % N;
            if (win < 0 && pend[l] && pexit[l]) win = l;
        end
`endif
        for (int k = 0; k < N; k++) begin
            l = (m_rr + k) % N;
            if (win < 0 && pend[l]) win = l;
        end
        if (win >= 0) begin
            resp_cyc    = cyc + 1;
            resp_lane   = win;
            m_rr        = (win + 1) % N;
            resp_ok_e   = 1'b0;
            resp_slot_e = 0;
            for (int s = 0; s < S; s++) m_new[s] = m_occ[s];
            if (pexit[win]) begin
                if (pslot[win] < S && m_occ[pslot[win]]) begin
                    resp_ok_e          = 1'b1;
                    resp_slot_e        = pslot[win];
                    m_new[pslot[win]]  = 1'b0;
                end
            end else begin
                for (int s = 0; s < S; s++) begin
                    if (!resp_ok_e && !m_occ[s]) begin
                        resp_ok_e   = 1'b1;
                        resp_slot_e = s;
                        m_new[s]    = 1'b1;
                    end
                end
            end
            next_arb = resp_ok_e ? cyc + 2 + D : cyc + 2;
        end
    endtask

    task automatic step(input bit rnd);
        int cnt;
        logic [N-1:0] ev;
        bit door_e;
        @(negedge clk);
        cyc++;
        if (cyc == resp_cyc + 1) for (int s = 0; s < S; s++) m_occ[s] = m_new[s];
        ev = '0;
        if (cyc == resp_cyc) ev[resp_lane] = 1'b1;
        check("resp_valid", resp_valid, ev);
        if (cyc == resp_cyc) begin
            check("resp_ok", resp_ok, resp_ok_e);
            check("resp_slot", resp_slot, resp_slot_e);
        end
        door_e = resp_ok_e && (cyc > resp_cyc) && (cyc <= resp_cyc + D);
        check("door_open", door_open, door_e);
        cnt = 0;
        for (int s = 0; s < S; s++) cnt += m_occ[s];
        check("occupancy", occupancy, occ_vec());
        check("free_count", free_count, S - cnt);
        check("full_light", full_light, cnt == S);
        if (cyc == resp_cyc) begin
            pend[resp_lane] = 1'b0;
        end else if (rnd) begin
            for (int l = 0; l < N; l++) begin
                if (!pend[l] && $urandom_range(0, 3) == 0)
                    req(l, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
            end
        end
        drive();
        if (cyc >= next_arb) arbitrate();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        for (int l = 0; l < N; l++) pend[l] = 1'b0;
        drive();
        #1;
        check("rst_door_open", door_open, 0);
        check("rst_occupancy", occupancy, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_ok", resp_ok, 0);
        check("rst_resp_slot", resp_slot, 0);
        check("rst_free_count", free_count, S);
        check("rst_full_light", full_light, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int s = 0; s < S; s++) m_occ[s] = 1'b0;
        m_rr      = 0;
        resp_cyc  = -100;
        resp_ok_e = 1'b0;
        next_arb  = 0;
        cyc       = 0;
    endtask

    task automatic drain();
        int b;
        bit busy;
        b = 0;
        busy = 1'b1;
        while (busy && b < 200) begin
            busy = 1'b0;
            for (int l = 0; l < N; l++) if (pend[l]) busy = 1'b1;
            if (busy) step(1'b0);
            b++;
        end
        check("drain_timeout", busy, 0);
        for (int i = 0; i < D + 2; i++) step(1'b0);
    endtask

    initial begin
        #2;
        do_reset();
        req(0, 1'b0, 0);
        drain();
        check("t1_occupancy", occupancy, 4'b0001);
        for (int l = 1; l < N; l++) req(l, 1'b0, 0);
        drain();
        req(0, 1'b0, 0);
        drain();
        check("t2_full_light", full_light, 1);
        check("t2_free_count", free_count, 0);
        req(2, 1'b1, 2);
        drain();
        check("t3_occupancy", occupancy, 4'b1011);
        req(1, 1'b0, 0);
        drain();

        do_reset();
        req(0, 1'b0, 0);
        drain();
        req(1, 1'b1, 1);
        drain();
        check("t4_occupancy", occupancy, 4'b0001);

        do_reset();
        for (int l = 0; l < N; l++) req(l, 1'b0, 0);
        drain();
        check("t5_occupancy", occupancy, 4'b1111);
        req(3, 1'b1, 3);
        req(0, 1'b1, 0);
        drain();

        do_reset();
        req(0, 1'b0, 0);
        step(1'b0);
        step(1'b0);
        step(1'b0);
        do_reset();
        for (int l = 0; l < N; l++) req(l, 1'b0, 0);
        drain();
        req(0, 1'b0, 0);
        req(3, 1'b1, 1);
        drain();

        do_reset();
        for (int i = 0; i < 3000; i++) step(1'b1);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
